// File: rtl/sar_adc_seq_pkg.sv
// Shared types and helpers for the SAR ADC sequencer: FSM states and the mask bit picker.
package sar_adc_seq_pkg;

  localparam int unsigned ADC_W  = 8;
  localparam int unsigned MAX_CH = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StStart,
    StConvert,
    StAccum,
    StEmit,
    StNext
  } seq_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } ch_pick_t;

  // Lowest set bit of mask strictly above cur, or the lowest set bit overall when first is set.
  function automatic ch_pick_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                            input logic [3:0]        cur,
                                            input logic              first);
    ch_pick_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (4'(i) > cur))) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sar_adc_sequencer_ch_next.sv
// Combinational priority picker: next enabled channel above the current one, or the first one.
module sar_ch_next #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask_i,
  input  logic [CH_W-1:0] cur_i,
  input  logic            first_i,
  output logic            found_o,
  output logic [CH_W-1:0] idx_o
);
  import sar_adc_seq_pkg::*;

  ch_pick_t pick;

  always_comb begin
    pick    = next_set_bit(MAX_CH'(mask_i), 4'(cur_i), first_i);
    found_o = pick.found;
    idx_o   = CH_W'(pick.idx);
  end

endmodule

// File: rtl/sar_adc_sequencer.sv
// Scans enabled mux channels, runs averaged SAR conversions with a timeout and streams the
// per-channel averages out on a valid/ready interface with sticky error reporting.
module sar_adc_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CH_W        = $clog2(N_CH),
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            trig_i,
  input  logic [N_CH-1:0] ch_mask_i,
  input  logic            clr_i,
  output logic [CH_W-1:0] mux_sel_o,
  output logic            adc_start_o,
  output logic            adc_rst_n_o,
  input  logic            adc_eoc_i,
  input  logic [7:0]      adc_dout_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [7:0]      res_data_o,
  output logic [CH_W-1:0] res_ch_o,
  output logic            busy_o,
  output logic            err_timeout_o,
  output logic            overrun_o
);
  import sar_adc_seq_pkg::*;

  localparam int unsigned AccW  = ADC_W + AVG_LOG2;
  localparam int unsigned NsW   = AVG_LOG2 + 1;
  localparam logic [NsW-1:0] NSamp = NsW'(1 << AVG_LOG2);

  seq_state_t       state_q;
  logic [N_CH-1:0]  mask_q;
  logic [CH_W-1:0]  ch_q, mux_sel_q, res_ch_q;
  logic [7:0]       cnt_q;
  logic [NsW-1:0]   nsamp_q, nsamp_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [ADC_W-1:0] sample_q, res_data_q, avg;
  logic             adc_start_q, adc_rst_n_q, res_valid_q, err_timeout_q, overrun_q;
  logic             transfer;

  logic             first_found, next_found;
  logic [CH_W-1:0]  first_idx, next_idx;

  sar_ch_next #(.N_CH(N_CH), .CH_W(CH_W)) u_first (
    .mask_i  (ch_mask_i),
    .cur_i   ('0),
    .first_i (1'b1),
    .found_o (first_found),
    .idx_o   (first_idx)
  );

  sar_ch_next #(.N_CH(N_CH), .CH_W(CH_W)) u_next (
    .mask_i  (mask_q),
    .cur_i   (ch_q),
    .first_i (1'b0),
    .found_o (next_found),
    .idx_o   (next_idx)
  );

  always_comb begin
    nsamp_d  = nsamp_q + 1'b1;
    acc_d    = acc_q + AccW'(sample_q);
    avg      = ADC_W'(acc_q >> AVG_LOG2);
    transfer = res_valid_q & res_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      ch_q          <= '0;
      mux_sel_q     <= '0;
      res_ch_q      <= '0;
      cnt_q         <= '0;
      nsamp_q       <= '0;
      acc_q         <= '0;
      sample_q      <= '0;
      res_data_q    <= '0;
      adc_start_q   <= 1'b0;
      adc_rst_n_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      adc_start_q <= 1'b0;
      adc_rst_n_q <= 1'b1;
      if (transfer) res_valid_q <= 1'b0;
      // Set events below are assigned later, so they win over a coincident clear.
      if (clr_i) begin
        err_timeout_q <= 1'b0;
        overrun_q     <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if ((en_i || trig_i) && first_found) begin
            mask_q  <= ch_mask_i;
            ch_q    <= first_idx;
            state_q <= StSelect;
          end
        end
        StSelect: begin
          mux_sel_q <= ch_q;
          cnt_q     <= 8'(SETTLE_CYC);
          acc_q     <= '0;
          nsamp_q   <= '0;
          state_q   <= StSettle;
        end
        StSettle: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            adc_start_q <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= 8'(TIMEOUT_CYC);
          state_q <= StConvert;
        end
        StConvert: begin
          if (adc_eoc_i) begin
            sample_q <= adc_dout_i;
            state_q  <= StAccum;
          end else if (cnt_q == 8'd1) begin
            err_timeout_q <= 1'b1;
            adc_rst_n_q   <= 1'b0;
            acc_q         <= '0;
            nsamp_q       <= '0;
            state_q       <= StNext;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StAccum: begin
          acc_q   <= acc_d;
          nsamp_q <= nsamp_d;
          if (nsamp_d == NSamp) begin
            state_q <= StEmit;
          end else begin
            adc_start_q <= 1'b1;
            state_q     <= StStart;
          end
        end
        StEmit: begin
          if (!res_valid_q || transfer) begin
            res_data_q  <= avg;
            res_ch_q    <= ch_q;
            res_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (next_found) begin
            ch_q    <= next_idx;
            state_q <= StSelect;
          end else if (en_i && first_found) begin
            mask_q  <= ch_mask_i;
            ch_q    <= first_idx;
            state_q <= StSelect;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mux_sel_o     = mux_sel_q;
  assign adc_start_o   = adc_start_q;
  assign adc_rst_n_o   = adc_rst_n_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_ch_o      = res_ch_q;
  assign busy_o        = (state_q != StIdle);
  assign err_timeout_o = err_timeout_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Scoreboard bench for sar_adc_sequencer with a behavioural ADC macro model.
module tb_sar_adc_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, trig, clr, adc_eoc, res_ready;
  logic [3:0] ch_mask;
  logic [7:0] adc_dout;
  logic [1:0] mux_sel_o, res_ch_o;
  logic [7:0] res_data_o;
  logic       adc_start_o, adc_rst_n_o, res_valid_o, busy_o, err_timeout_o, overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int ch;
    int data;
  } exp_t;
  exp_t sb[$];

  // ADC model state: every 4 consecutive conversions return base + {0,1,2,3} in some order.
  int         pend = 0, eoc_delay = 9, no_eoc_ch = -1, kcnt = 0;
  logic [7:0] pdata = '0;
  bit         supp = 1'b0;

  always #5 clk = ~clk;

  sar_adc_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .trig_i        (trig),
    .ch_mask_i     (ch_mask),
    .clr_i         (clr),
    .mux_sel_o     (mux_sel_o),
    .adc_start_o   (adc_start_o),
    .adc_rst_n_o   (adc_rst_n_o),
    .adc_eoc_i     (adc_eoc),
    .adc_dout_i    (adc_dout),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready),
    .res_data_o    (res_data_o),
    .res_ch_o      (res_ch_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o),
    .overrun_o     (overrun_o)
  );

  function automatic logic [7:0] base(input logic [1:0] ch);
    case (ch)
      2'd0:    return 8'h40;
      2'd1:    return 8'h80;
      2'd2:    return 8'h20;
      default: return 8'h10;
    endcase
  endfunction

  always @(negedge clk) begin
    adc_eoc = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !supp) begin
        adc_eoc  = 1'b1;
        adc_dout = pdata;
      end
    end
    if (adc_start_o) begin
      pend  = eoc_delay;
      pdata = base(mux_sel_o) + 8'(kcnt % 4);
      kcnt++;
      supp  = (int'(mux_sel_o) == no_eoc_ch);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input int data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int max);
    bit done = 1'b0;
    @(posedge clk);
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, max);
    end
  endtask

  // Monitor: compare every accepted result against the head of the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (res_valid_o && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got ch=%0d data=%0h, required no result",
                 res_ch_o, res_data_o);
      end else begin
        e = sb.pop_front();
        check("res_ch", 32'(res_ch_o), e.ch);
        check("res_data", 32'(res_data_o), e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    bit  found;
    rst = 1'b1; en = 1'b0; trig = 1'b0; clr = 1'b0; ch_mask = '0;
    res_ready = 1'b1; adc_eoc = 1'b0; adc_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_adc_rst_n", 32'(adc_rst_n_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_res_valid", 32'(res_valid_o), 0);
    check("rst_adc_start", 32'(adc_start_o), 0);
    check("rst_flags", {30'd0, err_timeout_o, overrun_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_adc_rst_n", 32'(adc_rst_n_o), 1);

    // Single scan over 1011, with settle timing measured from the trig edge.
    ch_mask = 4'b1011;
    trig    = 1'b1;
    push(0, 'h41); push(1, 'h81); push(3, 'h11);
    @(posedge clk);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      trig = 1'b0;
      if (j == 0) check("busy_after_trig", 32'(busy_o), 1);
      check($sformatf("adc_start_t%0d", j), 32'(adc_start_o), 32'(j == 5));
    end
    wait_idle("scan1_idle", 1000);
    @(negedge clk);
    check("scan1_drained", sb.size(), 0);
    check("scan1_flags", {30'd0, err_timeout_o, overrun_o}, 0);

    // Timeout on ch1.
    no_eoc_ch = 1;
    push(0, 'h41); push(3, 'h11);
    trig = 1'b1;
    @(negedge clk);
    trig  = 1'b0;
    t0    = -100;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (adc_start_o && mux_sel_o == 2'd1) t0 = i;
      if (err_timeout_o) begin
        found = 1'b1;
        check("timeout_delay", i - t0, 17);
        check("timeout_adc_rst_n", 32'(adc_rst_n_o), 0);
        check("timeout_ch", 32'(mux_sel_o), 1);
      end
    end
    check("timeout_seen", 32'(found), 1);
    @(negedge clk);
    check("timeout_adc_rst_n_restored", 32'(adc_rst_n_o), 1);
    wait_idle("timeout_idle", 1000);
    @(negedge clk);
    check("timeout_drained", sb.size(), 0);
    check("timeout_sticky", 32'(err_timeout_o), 1);
    no_eoc_ch = -1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("timeout_clr", 32'(err_timeout_o), 0);

    // Overrun: two results with the output stalled.
    res_ready = 1'b0;
    ch_mask   = 4'b0011;
    push(0, 'h41);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle("overrun_idle", 1000);
    @(negedge clk);
    check("overrun_valid", 32'(res_valid_o), 1);
    check("overrun_held_ch", 32'(res_ch_o), 0);
    check("overrun_held_data", 32'(res_data_o), 'h41);
    check("overrun_flag", 32'(overrun_o), 1);
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_one_transfer", sb.size(), 0);
    check("overrun_valid_cleared", 32'(res_valid_o), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("overrun_clr", 32'(overrun_o), 0);

    // Continuous scan with a mid-scan mask change, then en dropped during the second scan.
    push(0, 'h41); push(1, 'h81); push(0, 'h41); push(3, 'h11);
    ch_mask = 4'b0011;
    en      = 1'b1;
    @(negedge clk);
    ch_mask = 4'b1001;
    found   = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (mux_sel_o == 2'd3) found = 1'b1;
    end
    check("cont_reached_ch3", 32'(found), 1);
    en = 1'b0;
    wait_idle("cont_idle", 1000);
    @(negedge clk);
    check("cont_drained", sb.size(), 0);

    // Reset in the middle of a conversion on ch2; the late eoc must be ignored.
    ch_mask = 4'b0100;
    trig    = 1'b1;
    @(negedge clk);
    trig  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (adc_start_o) found = 1'b1;
    end
    check("rstmid_start_seen", 32'(found), 1);
    check("rstmid_mux_sel", 32'(mux_sel_o), 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_adc_rst_n_low", 32'(adc_rst_n_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_adc_rst_n", 32'(adc_rst_n_o), 1);
    check("rstmid_mux_sel_cleared", 32'(mux_sel_o), 0);
    check("rstmid_busy", 32'(busy_o), 0);
    check("rstmid_adc_start", 32'(adc_start_o), 0);
    repeat (12) @(negedge clk);
    check("rstmid_late_eoc_busy", 32'(busy_o), 0);
    check("rstmid_late_eoc_valid", 32'(res_valid_o), 0);
    check("rstmid_flags", {30'd0, err_timeout_o, overrun_o}, 0);
    check("final_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_sequencer.md
# sar_adc_sequencer

Digital controller that sequences the 8-bit SAR ADC hard macro across an external analog input mux. It scans enabled channels with a programmable settling delay, issues `start`, waits for `eoc` under a timeout, averages 2^AVG_LOG2 samples per channel, and presents results on a valid/ready stream. It sits between the ADC macro and the register/bus logic that consumes samples.

## Interface

**Parameters**
- `N_CH`, default 4: number of mux channels, 2..16.
- `CH_W`, default `$clog2(N_CH)`: channel index width.
- `SETTLE_CYC`, default 4: mux settling cycles before the first conversion of a channel, 1..255.
- `TIMEOUT_CYC`, default 16: maximum cycles from `adc_start` to `adc_eoc`, 2..255.
- `AVG_LOG2`, default 2: log2 of samples averaged per channel, 0..4.

**Ports**
- `clk` in 1: single clock, shared with the ADC macro.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: continuous scan enable.
- `trig` in 1: single-scan trigger, level-sampled.
- `ch_mask` in N_CH: enabled channels; bit i enables channel i.
- `clr` in 1: clears the sticky error flags.
- `mux_sel` out CH_W: analog mux select.
- `adc_start` out 1: one-cycle start pulse to the macro.
- `adc_rst_n` out 1: macro reset, active-low.
- `adc_eoc` in 1: macro end-of-conversion.
- `adc_dout` in 8: macro result.
- `res_valid` out 1: result stream valid.
- `res_ready` in 1: result stream ready.
- `res_data` out 8: averaged result.
- `res_ch` out CH_W: channel index of `res_data`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_timeout` out 1: sticky; a conversion timed out.
- `overrun` out 1: sticky; a result was dropped because the output was full.

## Operation

- **Reset values.** All outputs are 0 except `adc_rst_n`:
  - `adc_rst_n` is 0 while `rst` is high and 1 from the first cycle after `rst` deasserts.
  - The FSM goes to IDLE and the accumulator and counters clear.
- **FSM states:** IDLE, SELECT, SETTLE, START, CONVERT, ACCUM, EMIT, NEXT.
- **IDLE.**
  - If `en` or `trig` is high and `ch_mask` is nonzero, register `ch_mask` into `mask_q`, pick the lowest set bit as the channel, and go to SELECT.
  - If `ch_mask` is all zero, stay in IDLE; `trig` is ignored.
- **SELECT.** Drive `mux_sel` to the channel, load the settle counter with SETTLE_CYC, clear the accumulator and sample count, go to SETTLE.
- **SETTLE.** Decrement the counter; at 0 go to START.
- **START.** `adc_start` is high for exactly this cycle; load the timeout counter; go to CONVERT.
- **CONVERT.** Two exits:
  - First cycle `adc_eoc` is high: capture `adc_dout`, go to ACCUM.
  - Counter expires with no `eoc`: set `err_timeout`, drive `adc_rst_n` low for 1 cycle, discard the channel's partial accumulation, and go to NEXT. No result is emitted.
- **ACCUM.** Add the sample to the accumulator (width 8+AVG_LOG2, no overflow possible) and increment the count.
  - If count < 2^AVG_LOG2, go to START. There is no re-settle within a channel.
  - Otherwise go to EMIT.
- **EMIT.** Compute `acc >> AVG_LOG2`, truncated; with AVG_LOG2=0 this passes `adc_dout` through.
  - If `res_valid` is 0: load `res_data` and `res_ch`, and set `res_valid`.
  - If `res_valid` is 1: keep the held result, drop the new one, and set `overrun`.
  - Then go to NEXT.
- **NEXT.** Select the next set bit of `mask_q` above the current channel.
  - If one exists, go to SELECT.
  - Otherwise the scan is complete: if `en` is high, re-register `ch_mask` and go to SELECT on its lowest set bit (IDLE if it is zero); else go to IDLE.
- **Output handshake.** `res_valid` clears on the cycle a `res_valid && res_ready` transfer occurs. An EMIT in the same cycle as a transfer loads the new result, sets `res_valid`, and raises no overrun.
- **Sticky flags.**
  - `clr` clears both flags.
  - If `clr` and a set event coincide, the set event wins.
- **Mid-scan changes.**
  - Changes to `ch_mask` during a scan do not affect that scan.
  - `trig` while busy is ignored.
  - Deasserting `en` mid-scan finishes the current scan, then the FSM goes to IDLE.
- **Reset mid-conversion.** Abort immediately to the reset values; a late `eoc` is ignored because the FSM is in IDLE.

## Timing

- `trig` sampled at edge k: SELECT occurs in cycle k, and `mux_sel` is valid from edge k+1.
- `adc_start` is high in the cycle beginning at edge k+1+SETTLE_CYC.
- A conversion whose `eoc` arrives E cycles after `adc_start` reaches ACCUM one cycle after `eoc`.
- The final sample of a channel sets `res_valid` 2 cycles after its `eoc` edge (ACCUM, then EMIT).
- Per-sample overhead beyond conversion time is 2 cycles (ACCUM plus START).
- `adc_eoc` and `adc_dout` are synchronous to `clk`; no synchronizer is needed.

## Structure

- **Package `sar_adc_seq_pkg`:**
  - state enum `seq_state_t`;
  - `ADC_W = 8`;
  - a function returning the next set mask bit above a given index, with a found flag.
- **Sub-module `sar_ch_next`:** combinational priority picker over `mask_q` and the current index. Used for both the first channel and the next channel.

## Test plan

- **Single scan, full mask.** `ch_mask=4'b1011`, AVG_LOG2=2, macro model returns 8'h40, 8'h41, 8'h42, 8'h43 on ch0, with `eoc` 9 cycles after start.
  - Results: ch0=8'h41, then ch1, then ch3 (ch2 skipped).
  - `busy` drops after ch3.
- **Settle timing.** Pulse `trig` once; check `adc_start` is high exactly 1+SETTLE_CYC cycles after the trig edge, and high for one cycle only.
- **Timeout.** Macro never raises `eoc` on ch1.
  - After 16 cycles, `err_timeout=1`, `adc_rst_n` is low for 1 cycle, and no ch1 result is produced.
  - ch3 proceeds normally.
  - `clr` clears `err_timeout`.
- **Overrun.** Hold `res_ready=0` over two channel results.
  - The first result is retained, the second is dropped, and `overrun=1`.
  - Raise `res_ready`: exactly one transfer occurs.
- **Continuous scan.** `en=1` with `ch_mask` changed mid-scan.
  - The current scan completes with the old mask; the next scan uses the new mask.
  - Deasserting `en` ends the run after the current scan.
- **Reset mid-conversion.** Assert `rst` during CONVERT; a late `eoc` produces no result, and all outputs return to their reset values.
